// File: rtl/fe_mux_pkg.sv
// Shared types and constants for the front-end mux DDR lane serializer.
//   nibble_t     : one 4-bit sample word.
//   ser_state_t  : framing FSM states (IDLE, SYNC, DATA, PARITY).
//   SYNC_WORD_DEF / IDLE_WORD_DEF : default header and filler nibbles.
package fe_mux_pkg;

  typedef logic [3:0] nibble_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_DATA   = 2'd2,
    ST_PARITY = 2'd3
  } ser_state_t;

  localparam nibble_t SYNC_WORD_DEF = 4'hD;
  localparam nibble_t IDLE_WORD_DEF = 4'h0;

endpackage

// File: rtl/fe_ddr_lane_serializer_if.sv
// Sample-word input stream of the DDR lane serializer.
//   in_data  : 4-bit sample word
//   in_valid : in_data valid
//   in_ready : serializer can accept a word
// Handshake: a word transfers on every rising clk edge where in_valid and
// in_ready are both 1; once raised, in_valid and in_data hold steady until
// that transfer edge, and in_ready never depends combinationally on in_valid.
// Modports: master = word source, slave = serializer.
interface fe_ddr_lane_serializer_if;
  fe_mux_pkg::nibble_t in_data;
  logic                in_valid;
  logic                in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/fe_sync_fifo.sv
// Single-clock FIFO used as the sample buffer of the DDR lane serializer.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   flush          : synchronous clear of all entries (wins over push/pop)
//   push, wdata    : write request and data (accepted when not full, or
//                    when full and popping in the same cycle)
//   pop, rdata     : read request; rdata shows the head entry combinationally
//   full, empty    : occupancy flags derived from count
//   count          : number of stored entries
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module fe_sync_fifo #(
  parameter  int DEPTH = 8,
  parameter  int WIDTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  // A full FIFO still takes a word when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fe_ddr_lane_serializer.sv
// DDR lane serializer: buffers 4-bit sample words, frames them as
// SYNC_WORD followed by FRAME_WORDS data words, and sends each word over two
// clk cycles on one DDR lane (cycle A: bit0/bit1, cycle B: bit2/bit3).
// Ports:
//   clk, rst_n   : PLL global clock, asynchronous active-low reset
//   enable       : lane enable (PLL lock); low flushes and silences the lane
//   extclksync   : one-cycle pulse that restarts the word phase
//   in_if        : sample-word stream (in_data / in_valid / in_ready)
//   out_0        : rising-edge DDR bit
//   out_180      : falling-edge DDR bit
//   out_enable   : output-buffer enable, enable delayed by one cycle
//   frame_active : high while the FSM is in SYNC/DATA/PARITY
//   underrun     : one-cycle pulse when a data slot found the FIFO empty
//   dbg_state    : current framing FSM state
// Build option: define FE_SER_PARITY_EN to append a PARITY word (XOR of the
// frame's data words) after every frame.
module fe_ddr_lane_serializer
  import fe_mux_pkg::*;
#(
  parameter int      FIFO_DEPTH  = 8,
  parameter int      FRAME_WORDS = 16,
  parameter nibble_t SYNC_WORD   = SYNC_WORD_DEF,
  parameter nibble_t IDLE_WORD   = IDLE_WORD_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      extclksync,
  fe_ddr_lane_serializer_if.slave   in_if,
  output logic                      out_0,
  output logic                      out_180,
  output logic                      out_enable,
  output logic                      frame_active,
  output logic                      underrun,
  output ser_state_t                dbg_state
);

  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int WCW = $clog2(FRAME_WORDS + 1);

  // Word-phase and framing state
  logic            phase;       // 0: sending bit0/bit1, 1: sending bit2/bit3
  ser_state_t      state;
  nibble_t         cur_word;
  logic [WCW-1:0]  word_cnt;
  logic            in_ready_q;
`ifdef FE_SER_PARITY_EN
  nibble_t         par_acc;
  nibble_t         nxt_par;
`endif

  // FIFO connections
  nibble_t         fifo_rdata;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;
  logic            push_acc;
  logic            pop_req;
  logic            pop_acc;
  logic [CW-1:0]   cnt_nxt;

  // Next-boundary decisions
  ser_state_t      nxt_state;
  nibble_t         nxt_word;
  nibble_t         head_word;
  logic [WCW-1:0]  nxt_cnt;
  logic            und_nxt;

  assign in_if.in_ready = in_ready_q;
  assign dbg_state      = state;
  assign push_acc       = in_if.in_valid && in_ready_q;
  // The FIFO is only read at a word boundary of an enabled lane.
  assign pop_acc        = enable && phase && pop_req;

  fe_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (4)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (!enable),
    .push  (push_acc),
    .wdata (in_if.in_data),
    .pop   (pop_acc),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Occupancy after this edge, so in_ready never lets a word into a full FIFO.
  always_comb begin
    cnt_nxt = fifo_count;
    case ({push_acc, pop_acc})
      2'b10:   cnt_nxt = fifo_count + CW'(1);
      2'b01:   cnt_nxt = fifo_count - CW'(1);
      default: cnt_nxt = fifo_count;
    endcase
  end

  // Decision taken at the next word boundary. A data slot that finds the
  // FIFO empty still consumes a frame slot, sending IDLE_WORD instead.
  always_comb begin
    nxt_state = state;
    nxt_word  = IDLE_WORD;
    nxt_cnt   = word_cnt;
    und_nxt   = 1'b0;
    pop_req   = 1'b0;
    head_word = fifo_empty ? IDLE_WORD : fifo_rdata;
`ifdef FE_SER_PARITY_EN
    nxt_par   = par_acc;
`endif
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          nxt_word  = SYNC_WORD;
          nxt_state = ST_SYNC;
`ifdef FE_SER_PARITY_EN
          nxt_par   = '0;
`endif
        end
      end
      ST_SYNC: begin
        nxt_word  = head_word;
        pop_req   = !fifo_empty;
        und_nxt   = fifo_empty;
        nxt_cnt   = WCW'(1);
        nxt_state = ST_DATA;
`ifdef FE_SER_PARITY_EN
        nxt_par   = par_acc ^ head_word;
`endif
      end
      ST_DATA: begin
        if (word_cnt < WCW'(FRAME_WORDS)) begin
          nxt_word = head_word;
          pop_req  = !fifo_empty;
          und_nxt  = fifo_empty;
          nxt_cnt  = word_cnt + WCW'(1);
`ifdef FE_SER_PARITY_EN
          nxt_par  = par_acc ^ head_word;
`endif
        end else begin
`ifdef FE_SER_PARITY_EN
          nxt_word  = par_acc;
          nxt_state = ST_PARITY;
`else
          if (!fifo_empty) begin
            nxt_word  = SYNC_WORD;
            nxt_state = ST_SYNC;
          end else begin
            nxt_state = ST_IDLE;
          end
`endif
        end
      end
      ST_PARITY: begin
`ifdef FE_SER_PARITY_EN
        if (!fifo_empty) begin
          nxt_word  = SYNC_WORD;
          nxt_state = ST_SYNC;
          nxt_par   = '0;
        end else begin
          nxt_state = ST_IDLE;
        end
`else
        nxt_state = ST_IDLE;
`endif
      end
      default: nxt_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase        <= 1'b0;
      state        <= ST_IDLE;
      cur_word     <= IDLE_WORD;
      word_cnt     <= '0;
      out_0        <= 1'b0;
      out_180      <= 1'b0;
      out_enable   <= 1'b0;
      frame_active <= 1'b0;
      underrun     <= 1'b0;
      in_ready_q   <= 1'b0;
`ifdef FE_SER_PARITY_EN
      par_acc      <= '0;
`endif
    end else begin
      // The phase keeps running while disabled so framing can start at the
      // first boundary after enable rises.
      phase      <= extclksync ? 1'b0 : ~phase;
      out_enable <= enable;
      in_ready_q <= enable && (cnt_nxt != CW'(FIFO_DEPTH));
      if (!enable) begin
        state        <= ST_IDLE;
        cur_word     <= IDLE_WORD;
        word_cnt     <= '0;
        out_0        <= 1'b0;
        out_180      <= 1'b0;
        frame_active <= 1'b0;
        underrun     <= 1'b0;
`ifdef FE_SER_PARITY_EN
        par_acc      <= '0;
`endif
      end else if (!phase) begin
        out_0    <= cur_word[0];
        out_180  <= cur_word[1];
        underrun <= 1'b0;
      end else begin
        // Word boundary: last half of the current word goes out while the
        // next word is chosen.
        out_0        <= cur_word[2];
        out_180      <= cur_word[3];
        cur_word     <= nxt_word;
        state        <= nxt_state;
        word_cnt     <= nxt_cnt;
        underrun     <= und_nxt;
        frame_active <= (nxt_state != ST_IDLE);
`ifdef FE_SER_PARITY_EN
        par_acc      <= nxt_par;
`endif
      end
    end
  end

endmodule

// File: tb/tb_fe_ddr_lane_serializer.sv
// Testbench for fe_ddr_lane_serializer (FRAME_WORDS=4, FIFO_DEPTH=8).
// A word-level reference model builds frames as slot lists
// (SYNC, FRAME_WORDS data slots, optional PARITY) and queues the word the
// lane should carry; a monitor decodes the lane bit pairs back into words
// and compares them against that queue, plus per-cycle status outputs.
module tb_fe_ddr_lane_serializer;

  localparam int         FW     = 4;
  localparam int         DEPTH  = 8;
  localparam logic [3:0] SYNC_W = 4'hD;
  localparam logic [3:0] IDLE_W = 4'h0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic extclksync = 1'b0;
  always #5 clk = ~clk;

  fe_ddr_lane_serializer_if bus ();
  logic out_0, out_180, out_enable, frame_active, underrun;
  fe_mux_pkg::ser_state_t dbg_state;

  fe_ddr_lane_serializer #(
    .FIFO_DEPTH  (DEPTH),
    .FRAME_WORDS (FW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .extclksync   (extclksync),
    .in_if        (bus),
    .out_0        (out_0),
    .out_180      (out_180),
    .out_enable   (out_enable),
    .frame_active (frame_active),
    .underrun     (underrun),
    .dbg_state    (dbg_state)
  );

  int errors = 0;
  int checks = 0;
  int words_seen = 0;

  function automatic void chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  logic [3:0] exp_q[$];     // words the lane must carry, in order
  logic [3:0] m_q[$];       // model of buffered samples
  int         slots[$];     // remaining slots of the frame in progress: 1 sync, 2 data, 3 parity
  logic [3:0] m_cur = IDLE_W;
  logic [3:0] m_par = '0;
  bit m_phase = 0, m_ready = 0, m_und = 0, m_in_frame = 0, m_lo_ok = 0;
  bit mon_en = 0, mon_phase = 0;

  always @(posedge clk) begin
    bit pushed;
    logic [3:0] pd;
    int kind;
    pushed = bus.in_valid && m_ready;
    pd     = bus.in_data;
    if (!rst_n) begin
      m_q.delete(); slots.delete();
      m_cur = IDLE_W; m_phase = 0; m_ready = 0; m_und = 0;
      m_in_frame = 0; m_lo_ok = 0; mon_en = 0; mon_phase = 0;
    end else begin
      mon_en    = enable;
      mon_phase = m_phase;
      if (!enable) begin
        m_q.delete(); slots.delete();
        m_cur = IDLE_W; m_und = 0; m_in_frame = 0; m_lo_ok = 0; m_ready = 0;
      end else begin
        m_und = 0;
        if (m_phase == 0) begin
          m_lo_ok = 1;
        end else begin
          if (m_lo_ok) exp_q.push_back(m_cur);
          m_lo_ok = 0;
          if (slots.size() == 0 && m_q.size() != 0) begin
            slots.push_back(1);
            for (int i = 0; i < FW; i++) slots.push_back(2);
`ifdef FE_SER_PARITY_EN
            slots.push_back(3);
`endif
          end
          if (slots.size() == 0) begin
            m_cur = IDLE_W;
            m_in_frame = 0;
          end else begin
            kind = slots.pop_front();
            m_in_frame = 1;
            case (kind)
              1: begin m_cur = SYNC_W; m_par = '0; end
              2: begin
                if (m_q.size() != 0) m_cur = m_q.pop_front();
                else begin m_cur = IDLE_W; m_und = 1; end
                m_par = m_par ^ m_cur;
              end
              default: m_cur = m_par;
            endcase
          end
        end
        if (pushed) m_q.push_back(pd);
        m_ready = (m_q.size() < DEPTH);
      end
      m_phase = extclksync ? 1'b0 : ~m_phase;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [1:0] lo = '0;
  bit have_lo = 0;
  always @(negedge clk) begin
    logic [3:0] w;
    chk("out_enable", out_enable, mon_en);
    chk("in_ready", bus.in_ready, m_ready);
    chk("underrun", underrun, m_und);
    chk("frame_active", frame_active, m_in_frame);
    if (!mon_en) begin
      chk("out_0_off", out_0, 0);
      chk("out_180_off", out_180, 0);
      have_lo = 0;
    end else if (!mon_phase) begin
      lo = {out_180, out_0};
      have_lo = 1;
    end else if (have_lo) begin
      w = {out_180, out_0, lo};
      have_lo = 0;
      words_seen++;
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL word: got %0h expected nothing queued at %0t", w, $time);
      end else begin
        chk("word", w, exp_q.pop_front());
      end
    end
  end

  // ---------------- extclksync driver ----------------
  bit sync_rand = 0;
  bit force_sync = 0;
  initial forever begin
    @(negedge clk);
    #1;
    extclksync = force_sync || (sync_rand && ($urandom_range(0, 11) == 0));
    force_sync = 0;
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_word(input logic [3:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    for (int t = 0; t < 100; t++) begin
      if (bus.in_ready) begin
        @(negedge clk);
        bus.in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    checks++; errors++;
    $display("FAIL push_timeout: got in_ready=0 expected 1 within 100 cycles");
    bus.in_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    rst_n = 1'b0; enable = 1'b0;
    tick(4);
    rst_n = 1'b1;
    tick(5);
    enable = 1'b1;
    tick(4);
    force_sync = 1;
    tick(2);
    // single frame
    push_word(4'h1); push_word(4'h2); push_word(4'h3); push_word(4'h4);
    tick(24);
    // underrun: two data slots left empty
    push_word(4'h1); push_word(4'h2);
    tick(24);
    // back-to-back: enough words to fill the buffer
    for (int i = 0; i < 20; i++) push_word(4'(i + 5));
    tick(40);
    // resync on a boundary cycle in the middle of a frame
    push_word(4'h5); push_word(4'h6); push_word(4'h7);
    tick(3);
    for (int t = 0; t < 8 && m_phase != 1; t++) @(negedge clk);
    force_sync = 1;
    tick(30);
    // parity pattern, two frames back to back
    push_word(4'h1); push_word(4'h2); push_word(4'h4); push_word(4'h8);
    push_word(4'h1); push_word(4'h2); push_word(4'h4); push_word(4'h8);
    tick(30);
    // randomized traffic with resyncs and enable drops
    sync_rand = 1;
    repeat (250) begin
      tick($urandom_range(0, 5));
      if ($urandom_range(0, 39) == 0) begin
        enable = 1'b0;
        tick($urandom_range(1, 4));
        enable = 1'b1;
      end
      push_word(4'($urandom_range(0, 15)));
    end
    sync_rand = 0;
    tick(80);
    checks++;
    if (words_seen < 100) begin
      errors++;
      $display("FAIL words_seen: got %0d expected at least 100", words_seen);
    end
    checks++;
    if (exp_q.size() > 2) begin
      errors++;
      $display("FAIL exp_left: got %0d expected at most 2", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

endmodule
